// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a FETCH/WAIT/ISSUE sequencer that reads 16-bit instructions from program
// memory, holds the issued word while decode stalls, and redirects the PC on branch or flush.
module instruction_fetch #(
    parameter int                    PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          pcInMux_ctrl,
    input  logic [PC_WIDTH-1:0] branch_addr,
    input  logic [PC_WIDTH-1:0] acc_addr,
    input  logic                stall,
    input  logic                flush,
    output logic                pm_req,
    output logic [PC_WIDTH-1:0] pm_addr,
    input  logic                pm_ack,
    input  logic [15:0]         pm_rdata,
    output logic [15:0]         instruction,
    output logic [7:0]          OP_dk,
    output logic [3:0]          OP_s,
    output logic [6:0]          dma,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [1:0]          state_dbg
);

    // Handshake: a read is outstanding while pm_req=1; pm_addr is frozen until the cycle
    // pm_ack=1 is sampled, which completes it. pm_ack is ignored whenever pm_req=0.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t              state;
    logic                discard;
    logic [PC_WIDTH-1:0] redirect_addr;
    logic [PC_WIDTH-1:0] next_pc;

    always_comb begin
        next_pc = pc + PC_WIDTH'(1);
        case (pcInMux_ctrl)
            2'b00:   next_pc = branch_addr;
            2'b01:   next_pc = acc_addr;
            2'b10:   next_pc = pc;
            default: next_pc = pc + PC_WIDTH'(1);
        endcase
    end

    assign OP_dk     = instruction[15:8];
    assign OP_s      = instruction[15:12];
    assign dma       = instruction[6:0];
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            pm_addr       <= RESET_VECTOR;
            redirect_addr <= RESET_VECTOR;
            pc            <= RESET_VECTOR;
            instruction   <= 16'h0000;
            instr_valid   <= 1'b0;
            pm_req        <= 1'b0;
            discard       <= 1'b0;
        end else begin
            case (state)
                FETCH, WAIT: begin
                    if (!pm_req) begin
                        // First cycle after reset: nothing is outstanding yet, so open the request.
                        pm_req <= 1'b1;
                        if (flush) pm_addr <= branch_addr;
                    end else if (flush) begin
                        // A request already on the bus must not move its address before the ack,
                        // so an unacked flush parks the target and drops the returning word.
                        if (pm_ack) begin
                            pm_addr <= branch_addr;
                            discard <= 1'b0;
                            state   <= FETCH;
                        end else begin
                            discard       <= 1'b1;
                            redirect_addr <= branch_addr;
                            state         <= WAIT;
                        end
                    end else if (pm_ack) begin
                        if (discard) begin
                            discard <= 1'b0;
                            pm_addr <= redirect_addr;
                            state   <= FETCH;
                        end else begin
                            instruction <= pm_rdata;
                            pc          <= pm_addr;
                            instr_valid <= 1'b1;
                            pm_req      <= 1'b0;
                            state       <= ISSUE;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        pm_addr     <= branch_addr;
                        instr_valid <= 1'b0;
                        pm_req      <= 1'b1;
                        state       <= FETCH;
                    end else if (!stall) begin
                        pm_addr     <= next_pc;
                        instr_valid <= 1'b0;
                        pm_req      <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state       <= FETCH;
                    pm_req      <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized traffic, every cycle
// compared against a transaction-level model of the fetch/issue behaviour.
module tb_instruction_fetch;

    localparam int              PW = 12;
    localparam logic [PW-1:0]   RV = '0;
    localparam int              ADDR_SPAN = 1 << PW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    pcInMux_ctrl = 2'b11;
    logic [PW-1:0] branch_addr = '0;
    logic [PW-1:0] acc_addr = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          pm_req;
    logic [PW-1:0] pm_addr;
    logic          pm_ack = 1'b0;
    logic [15:0]   pm_rdata = '0;
    logic [15:0]   instruction;
    logic [7:0]    OP_dk;
    logic [3:0]    OP_s;
    logic [6:0]    dma;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_WIDTH(PW), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .pcInMux_ctrl(pcInMux_ctrl),
        .branch_addr(branch_addr), .acc_addr(acc_addr), .stall(stall), .flush(flush),
        .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_rdata(pm_rdata),
        .instruction(instruction), .OP_dk(OP_dk), .OP_s(OP_s), .dma(dma),
        .instr_valid(instr_valid), .pc(pc), .state_dbg(state_dbg)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: what is requested, what is issued, and whether a flushed read is pending.
    bit          m_req, m_valid, m_disc;
    int          m_addr, m_pc, m_redir;
    logic [15:0] m_instr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int target(input bit [1:0] c, input int br, input int ac, input int cur);
        case (c)
            2'd0:    return br;
            2'd1:    return ac;
            2'd2:    return cur;
            default: return (cur + 1) % ADDR_SPAN;
        endcase
    endfunction

    task automatic model_update(input bit r, f, s, input bit [1:0] c, input int br, ac,
                                input bit a, input logic [15:0] d);
        if (r) begin
            m_req = 0; m_valid = 0; m_disc = 0;
            m_addr = int'(RV); m_pc = int'(RV); m_redir = int'(RV); m_instr = 16'h0000;
        end else if (m_valid) begin
            if (f || !s) begin
                m_valid = 0;
                m_req   = 1;
                m_addr  = f ? br : target(c, br, ac, m_pc);
            end
        end else if (!m_req) begin
            m_req = 1;
            if (f) m_addr = br;
        end else if (f) begin
            if (a) begin
                m_addr = br; m_disc = 0;
            end else begin
                m_disc = 1; m_redir = br;
            end
        end else if (a) begin
            if (m_disc) begin
                m_disc = 0; m_addr = m_redir;
            end else begin
                m_valid = 1; m_req = 0; m_instr = d; m_pc = m_addr;
            end
        end
    endtask

    task automatic step(input bit r, f, s, input bit [1:0] c, input logic [PW-1:0] br,
                        input logic [PW-1:0] ac, input bit a, input logic [15:0] d);
        reset = r; flush = f; stall = s; pcInMux_ctrl = c;
        branch_addr = br; acc_addr = ac; pm_ack = a; pm_rdata = d;
        model_update(r, f, s, c, int'(br), int'(ac), a, d);
        @(posedge clk);
        @(negedge clk);
        check_eq("pm_req", pm_req, m_req);
        if (m_req || r) check_eq("pm_addr", pm_addr, m_addr);
        check_eq("instr_valid", instr_valid, m_valid);
        check_eq("instruction", instruction, m_instr);
        check_eq("pc", pc, m_pc);
        check_eq("OP_dk", OP_dk, m_instr >> 8);
        check_eq("OP_s", OP_s, m_instr >> 12);
        check_eq("dma", dma, m_instr % 128);
        check_eq("state_issue", state_dbg == 2'd2, m_valid);
    endtask

    task automatic idle(input bit s, input bit [1:0] c, input bit a, input logic [15:0] d);
        step(1'b0, 1'b0, s, c, 12'h000, 12'h000, a, d);
    endtask

    initial begin
        // Reset release, two back-to-back immediate-ack fetches.
        step(1, 0, 0, 2'b11, 12'h000, 12'h000, 1, 16'h1111);
        step(1, 0, 0, 2'b11, 12'h000, 12'h000, 0, 16'h0000);
        check_eq("rst_req", pm_req, 1'b0);
        check_eq("rst_instr", instruction, 16'h0000);
        idle(0, 2'b11, 0, 16'h0);
        check_eq("s1_addr0", pm_addr, 12'h000);
        idle(0, 2'b11, 1, 16'h7F88);
        check_eq("s1_instr", instruction, 16'h7F88);
        check_eq("s1_pc", pc, 12'h000);
        idle(0, 2'b11, 0, 16'h0);
        check_eq("s1_addr1", pm_addr, 12'h001);
        idle(0, 2'b11, 1, 16'h6A05);
        check_eq("s1_opdk", OP_dk, 8'h6A);
        check_eq("s1_dma", dma, 7'h05);

        // Delayed ack: three WAIT cycles, then issue one cycle after the ack.
        idle(0, 2'b11, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            idle(0, 2'b11, 0, 16'h0);
            check_eq("s2_addr_stable", pm_addr, 12'h002);
        end
        check_eq("s2_not_valid", instr_valid, 1'b0);
        idle(0, 2'b11, 1, 16'h3C3C);
        check_eq("s2_valid", instr_valid, 1'b1);

        // Stall holds the issue stage; request only after stall drops.
        for (int i = 0; i < 4; i++) idle(1, 2'b00, 0, 16'h0);
        check_eq("s3_req_during_stall", pm_req, 1'b0);
        check_eq("s3_instr_held", instruction, 16'h3C3C);

        // Branch target, then PC wrap from 0xFFF.
        step(0, 0, 0, 2'b00, 12'h123, 12'h000, 0, 16'h0);
        check_eq("s4_branch", pm_addr, 12'h123);
        idle(0, 2'b11, 1, 16'h4444);
        step(0, 0, 0, 2'b01, 12'h000, 12'hFFF, 0, 16'h0);
        idle(0, 2'b11, 1, 16'h5555);
        check_eq("s4_pc_fff", pc, 12'hFFF);
        idle(0, 2'b11, 0, 16'h0);
        check_eq("s4_wrap", pm_addr, 12'h000);

        // Flush during WAIT: the late word is dropped and fetch resumes at the flush target.
        idle(0, 2'b11, 0, 16'h0);
        step(0, 1, 0, 2'b11, 12'h040, 12'h000, 0, 16'h0);
        idle(0, 2'b11, 0, 16'h0);
        idle(0, 2'b11, 1, 16'hBEEF);
        check_eq("s5_no_valid", instr_valid, 1'b0);
        check_eq("s5_addr", pm_addr, 12'h040);
        check_eq("s5_no_beef", instruction == 16'hBEEF, 1'b0);

        // Reset mid-WAIT with a coincident ack.
        idle(0, 2'b11, 0, 16'h0);
        step(1, 0, 0, 2'b11, 12'h000, 12'h000, 1, 16'h1234);
        check_eq("s6_req", pm_req, 1'b0);
        check_eq("s6_valid", instr_valid, 1'b0);
        check_eq("s6_instr", instruction, 16'h0000);
        idle(0, 2'b11, 0, 16'h0);
        check_eq("s6_addr", pm_addr, RV);

        // Randomized traffic, including spurious acks and acks during reset.
        for (int n = 0; n < 3000; n++) begin
            bit          r, f, s, a;
            bit [1:0]    c;
            logic [PW-1:0] br, ac;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 10);
            s  = ($urandom_range(0, 99) < 35);
            c  = 2'($urandom_range(0, 3));
            br = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
            ac = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
            a  = m_req ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 15);
            step(r, f, s, c, br, ac, a, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 12, program-counter and program-memory address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pcInMux_ctrl  input  2  next-PC select: 00 branch_addr, 01 acc_addr, 10 hold PC, 11 PC+1.
REQ-006 SHALL have port branch_addr  input  PC_WIDTH  branch/call target.
REQ-007 SHALL have port acc_addr  input  PC_WIDTH  accumulator-sourced target, taken from the low bits of the accumulator.
REQ-008 SHALL have port stall  input  1  downstream not ready; holds the issued instruction.
REQ-009 SHALL have port flush  input  1  redirect the PC to branch_addr and discard any in-flight fetch.
REQ-010 SHALL have port pm_req  output  1  program-memory read request.
REQ-011 SHALL have port pm_addr  output  PC_WIDTH  program-memory read address.
REQ-012 SHALL have port pm_ack  input  1  read data valid on pm_rdata this cycle.
REQ-013 SHALL have port pm_rdata  input  16  program-memory read data.
REQ-014 SHALL have port instruction  output  16  instruction register, fed to the decode lookup table.
REQ-015 SHALL have port OP_dk  output  8  instruction[15:8].
REQ-016 SHALL have port OP_s  output  4  instruction[15:12].
REQ-017 SHALL have port dma  output  7  instruction[6:0], direct data-memory address.
REQ-018 SHALL have port instr_valid  output  1  instruction, OP_dk, OP_s and dma are valid for decode.
REQ-019 SHALL have port pc  output  PC_WIDTH  address of the instruction currently held in the instruction register.

Function
REQ-020 SHALL implement the states FETCH, WAIT and ISSUE.
REQ-021 FETCH: SHALL drive pm_req=1 and pm_addr=pc_next_fetch; on pm_ack, capture pm_rdata into the instruction register and go to ISSUE; otherwise go to WAIT.
REQ-022 WAIT: SHALL hold pm_req=1 with pm_addr unchanged; on pm_ack, capture pm_rdata and go to ISSUE.
REQ-023 pm_addr SHALL NOT change while pm_req=1 and no pm_ack has been received.
REQ-024 ISSUE: SHALL drive instr_valid=1; while stall=1, SHALL remain in ISSUE with the instruction register, pc and instr_valid all held.
REQ-025 ISSUE with stall=0: SHALL select the next fetch address from pcInMux_ctrl using the issued pc, then go to FETCH.
REQ-026 PC+1 SHALL wrap modulo 2^PC_WIDTH (for example 0xFFF -> 0x000).
REQ-027 instr_valid SHALL be 0 in the FETCH and WAIT states.
REQ-028 Fetch latency SHALL be: pm_ack in the FETCH cycle -> instr_valid=1 on the next cycle; minimum of 2 cycles per instruction.
REQ-029 The field outputs OP_dk, OP_s and dma SHALL be combinational slices of the instruction register.
REQ-030 flush in FETCH or ISSUE SHALL set the fetch address to branch_addr, drive instr_valid=0 on the next cycle, and go to FETCH.
REQ-031 flush in WAIT SHALL set a discard flag and latch branch_addr; the pending pm_ack SHALL be consumed without loading the instruction register; the block SHALL then go to FETCH at the latched address.
REQ-032 flush SHALL take priority over stall and over pcInMux_ctrl.
REQ-033 A pm_ack arriving while pm_req=0 SHALL be ignored.

Reset
REQ-034 While reset=1, the block SHALL hold: state=FETCH, fetch address=RESET_VECTOR, pc=RESET_VECTOR, instruction=16'h0000, instr_valid=0, pm_req=0, discard flag=0.
REQ-035 On the first cycle after reset deasserts, the block SHALL drive pm_req=1 and pm_addr=RESET_VECTOR.
REQ-036 reset SHALL abort any outstanding fetch, and a pm_ack received during reset SHALL be ignored.

Verification
REQ-037 Scenario: reset release; memory acks immediately with 0x7F88, then 0x6A05 at address 1, pcInMux_ctrl=11 -> pm_addr 0 then 1; instruction 0x7F88 issued with pc=0; OP_dk=0x6A and dma=0x05 on the second issue.
REQ-038 Scenario: pm_ack delayed 3 cycles -> pm_req held with pm_addr stable across the WAIT cycles; instr_valid rises exactly 1 cycle after pm_ack.
REQ-039 Scenario: stall=1 for 4 cycles during ISSUE -> instruction, pc and instr_valid=1 constant; no pm_req until the cycle after stall falls.
REQ-040 Scenario: pcInMux_ctrl=00 with branch_addr=0x123 at issue -> next pm_addr=0x123; with pc=0xFFF and pcInMux_ctrl=11 -> next pm_addr=0x000.
REQ-041 Scenario: flush with branch_addr=0x040 during WAIT, pm_ack returns 0xBEEF 2 cycles later -> 0xBEEF never appears on instruction; next pm_addr=0x040.
REQ-042 Scenario: reset asserted mid-WAIT with pm_ack in the same cycle -> pm_req=0, instr_valid=0, instruction=0x0000; after release, pm_addr=RESET_VECTOR.
